// File: rtl/gray_counter.sv
// Up/down Gray-code counter with load, enable and wrap/saturate limits.
// Binary and Gray forms are both registered from the same next value.
module gray_counter #(
    parameter int          WIDTH   = 4,
    parameter bit          WRAP    = 1'b1,
    parameter int unsigned RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             wrap,
    output logic             at_limit
);

    localparam logic [WIDTH-1:0] MAX_VAL  = '1;
    localparam logic [WIDTH-1:0] RST_BIN  = RST_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);

    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             wrap_q, wrap_d;
    logic             at_limit_q, at_limit_d;

    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (load) begin
            bin_d = load_val;
        end else if (en) begin
            if (up_dn) begin
                if (bin_q != MAX_VAL) begin
                    bin_d = bin_q + 1'b1;
                end else if (WRAP) begin
                    bin_d  = '0;
                    wrap_d = 1'b1;
                end
            end else begin
                if (bin_q != '0) begin
                    bin_d = bin_q - 1'b1;
                end else if (WRAP) begin
                    bin_d  = MAX_VAL;
                    wrap_d = 1'b1;
                end
            end
        end
        // Gray taken from the next value so it lands on the same edge as bin.
        gray_d     = bin_d ^ (bin_d >> 1);
        at_limit_d = up_dn ? (bin_d == MAX_VAL) : (bin_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q      <= RST_BIN;
            gray_q     <= RST_GRAY;
            wrap_q     <= 1'b0;
            at_limit_q <= 1'b0;
        end else begin
            bin_q      <= bin_d;
            gray_q     <= gray_d;
            wrap_q     <= wrap_d;
            at_limit_q <= at_limit_d;
        end
    end

    assign bin_out  = bin_q;
    assign gray_out = gray_q;
    assign wrap     = wrap_q;
    assign at_limit = at_limit_q;

endmodule

// File: doc/gray_counter.md
Name: gray_counter

Overview:
Parametrised Gray-code counter; generalises the 4-bit combinational binary-to-Gray converter into a clocked block.
- Registered up/down counter with synchronous load, enable and selectable wrap/saturate mode.
- Presents the count in both binary and Gray form.
- Used wherever a multi-bit count must change exactly one bit per step, e.g. pointers, position encoders, low-glitch state buses.

Parameters:
WIDTH, 4, counter width in bits (>= 2).
WRAP, 1, 1 = modulo-2^WIDTH wrap at limits; 0 = saturate at limits.
RST_VAL, 0, binary count value loaded on reset (must fit in WIDTH bits).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
en  input  1  count enable; one step per clock while high.
up_dn  input  1  direction: 1 = increment, 0 = decrement.
load  input  1  synchronous load strobe.
load_val  input  WIDTH  binary value loaded when load=1.
bin_out  output  WIDTH  registered binary count.
gray_out  output  WIDTH  registered Gray encoding of bin_out.
wrap  output  1  registered one-cycle pulse on a wrap event.
at_limit  output  1  registered; high when the next step in the current direction would wrap or saturate.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (rst_n low, takes effect immediately, independent of clk):
  - bin_out = RST_VAL
  - gray_out = RST_VAL ^ (RST_VAL >> 1)
  - wrap = 0
  - at_limit = 0
- Release of rst_n is not synchronised inside the block; the integrator supplies a synchronised deassertion.
- All outputs are registered; no combinational path from any input to any output. Latency is 1 clock from input sample to output change.
- Invariant, every cycle after reset: gray_out == bin_out ^ (bin_out >> 1). gray_out is computed from the next binary value and registered in the same edge; it is not derived combinationally from bin_out.
- Priority per rising edge: load > en > hold.
  - load=1: bin_out <= load_val; gray_out <= Gray(load_val); wrap <= 0; en and up_dn are ignored.
  - load=0, en=1, up_dn=1:
    - bin_out < 2^WIDTH-1: increment; wrap <= 0.
    - bin_out == 2^WIDTH-1 and WRAP=1: next value 0; wrap <= 1.
    - bin_out == 2^WIDTH-1 and WRAP=0: hold; wrap <= 0.
  - load=0, en=1, up_dn=0:
    - bin_out > 0: decrement; wrap <= 0.
    - bin_out == 0 and WRAP=1: next value 2^WIDTH-1; wrap <= 1.
    - bin_out == 0 and WRAP=0: hold; wrap <= 0.
  - load=0, en=0: bin_out and gray_out hold; wrap <= 0.
- wrap is high for exactly one cycle per wrap event. Consecutive wraps (e.g. WIDTH=2 up-count with continuous en) pulse on each event.
- at_limit is registered from the next-state value and the up_dn sampled in the same cycle:
  - 1 if (up_dn=1 and next bin == 2^WIDTH-1) or (up_dn=0 and next bin == 0)
  - Not updated by an up_dn change alone until the next edge.
- Each en step changes gray_out by exactly one bit, including across the wrap boundary in both directions. A load may change any number of bits.
- Arithmetic is unsigned modulo 2^WIDTH. No intermediate wider than WIDTH+1 bits.
- Reset asserted mid-count overrides everything; the first count after release starts from RST_VAL.

Test Plan:
1. WIDTH=4, WRAP=1, reset, en=1, up_dn=1 for 17 clocks -> gray_out sequence 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000; wrap=1 only in the cycle gray_out returns to 0000; at_limit=1 while bin_out=1111.
2. From reset (bin 0), en=1, up_dn=0 one clock -> bin_out=1111, gray_out=1000, wrap=1; next clock -> bin_out=1110, gray_out=1001, wrap=0.
3. load=1, load_val=1010, en=1, up_dn=1 in the same cycle -> next edge bin_out=1010, gray_out=1111, wrap=0; load wins over en. Following enabled step -> bin_out=1011, gray_out=1110.
4. WRAP=0: load 1111, then en=1, up_dn=1 for 3 clocks -> bin_out stays 1111, gray_out stays 1000, wrap stays 0. Switch up_dn=0 -> bin_out=1110.
5. Counting at bin_out=0101, drive rst_n low mid-cycle with RST_VAL=0 -> outputs go to 0/0000 before the next clk edge. Release rst_n with en=1 -> first edge gives 0001.
6. WIDTH=8 randomised en/up_dn/load for 10000 cycles against a reference model:
   - invariant gray_out == bin_out ^ (bin_out >> 1) holds every cycle;
   - Hamming distance 1 on every non-load, non-held step.
